// File: rtl/and_reduce_seq_pkg.sv
// Shared constants and FSM encoding for the byte-serial AND/zero reduction sequencer.
package and_reduce_seq_pkg;
  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = 3;

  // 2'b11 is not a legal state; the sequencer decodes it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/and_reduce_seq_slice.sv
// Combinational 8-bit AND/OR reduce slice built as balanced 2-input gate trees.
module reduce_slice8
  import and_reduce_seq_pkg::*;
(
  input  logic [SLICE-1:0] slice_in,
  output logic             slice_and,
  output logic             slice_or
);
  logic [3:0] l1_and, l1_or;
  logic [1:0] l2_and, l2_or;

  for (genvar i = 0; i < 4; i++) begin : g_l1
    assign l1_and[i] = slice_in[2*i] & slice_in[2*i+1];
    assign l1_or[i]  = slice_in[2*i] | slice_in[2*i+1];
  end

  for (genvar i = 0; i < 2; i++) begin : g_l2
    assign l2_and[i] = l1_and[2*i] & l1_and[2*i+1];
    assign l2_or[i]  = l1_or[2*i]  | l1_or[2*i+1];
  end

  assign slice_and = l2_and[0] & l2_and[1];
  assign slice_or  = l2_or[0]  | l2_or[1];
endmodule

// File: rtl/and_reduce_seq.sv
// Byte-serial AND / zero-detect sequencer: one slice per cycle, LSB first, early exit
// once the operand is known to contain both a 0 and a 1.
module and_reduce_seq
  import and_reduce_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_steps
);
  localparam int              IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_e                      state_q, state_d;
  logic [NSLICE-1:0][SLICE-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        acc_and_q, acc_and_d;
  logic                        acc_or_q, acc_or_d;
  logic                        slice_and, slice_or;

  reduce_slice8 u_slice (
    .slice_in  (opnd_q[cnt_q[IDX_W-1:0]]),
    .slice_and (slice_and),
    .slice_or  (slice_or)
  );

  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    acc_and_d = acc_and_q;
    acc_or_d  = acc_or_q;
    case (state_q)
      RUN: begin
        acc_and_d = acc_and_q & slice_and;
        acc_or_d  = acc_or_q | slice_or;
        cnt_d     = cnt_q + CNT_W'(1);
        // A 0 and a 1 already seen fixes both results; no need to look further.
        if ((!acc_and_d && acc_or_d) || cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        if (in_valid) begin
          opnd_d    = in_data;
          cnt_d     = '0;
          acc_and_d = 1'b1;
          acc_or_d  = 1'b0;
          state_d   = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      opnd_q    <= '0;
      cnt_q     <= '0;
      acc_and_q <= 1'b0;
      acc_or_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      acc_and_q <= acc_and_d;
      acc_or_q  <= acc_or_d;
    end
  end

  assign in_ready  = !(state_q == RUN || state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign out_and   = out_valid & acc_and_q;
  assign out_zero  = out_valid & ~acc_or_q;
  assign out_steps = out_valid ? cnt_q : '0;
endmodule
